// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter for the single reg_file write port, plus a 16-entry pending-write
// scoreboard for RAW stalls. Define REG_ARB_STATS_EN to add the conflict_cnt_o counter.
module reg_write_arbiter #(
    parameter int N    = 32,
    parameter int NREQ = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid_i,
    input  logic [4*NREQ-1:0] req_addr_i,
    input  logic [N*NREQ-1:0] req_data_i,
    output logic [NREQ-1:0]   req_ready_o,
    output logic              wr_en_o,
    output logic [3:0]        wr_addr_o,
    output logic [N-1:0]      wr_data_o,
    output logic              err_pc_write_o,
    input  logic              reserve_valid_i,
    input  logic [3:0]        reserve_addr_i,
    input  logic [11:0]       chk_addr_i,
    input  logic [2:0]        chk_en_i,
    output logic [2:0]        busy_o,
    output logic              stall_o
`ifdef REG_ARB_STATS_EN
    ,
    output logic [15:0]       conflict_cnt_o
`endif
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [IW-1:0] last_q, last_d, grant_idx, cand;
    logic          grant_vld;
    logic [3:0]    grant_addr;
    logic [N-1:0]  grant_data;
    logic          wr_en_q, wr_en_d, err_q, err_d;
    logic [3:0]    wr_addr_q, wr_addr_d;
    logic [N-1:0]  wr_data_q, wr_data_d;
    logic [15:0]   pending_q, pending_d;

    // Search starts one past the last winner and wraps.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = last_q;
        cand      = '0;
        for (int i = 1; i <= NREQ; i++) begin
            cand = IW'((int'(last_q) + i) % NREQ);
            if (!grant_vld && req_valid_i[cand]) begin
                grant_vld = 1'b1;
                grant_idx = cand;
            end
        end
        req_ready_o = '0;
        grant_addr  = '0;
        grant_data  = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (grant_vld && grant_idx == IW'(k)) begin
                req_ready_o[k] = 1'b1;
                grant_addr     = req_addr_i[4*k +: 4];
                grant_data     = req_data_i[N*k +: N];
            end
        end
    end

    // R15 is granted but never written; it raises the error pulse instead.
    always_comb begin
        last_d    = grant_vld ? grant_idx : last_q;
        wr_en_d   = grant_vld && (grant_addr != 4'd15);
        err_d     = grant_vld && (grant_addr == 4'd15);
        wr_addr_d = wr_en_d ? grant_addr : wr_addr_q;
        wr_data_d = wr_en_d ? grant_data : wr_data_q;
        pending_d = pending_q;
        if (wr_en_q)
            pending_d[wr_addr_q] = 1'b0;
        if (reserve_valid_i)
            pending_d[reserve_addr_i] = 1'b1;
        pending_d[15] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q    <= IW'(NREQ - 1);
            wr_en_q   <= 1'b0;
            err_q     <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            pending_q <= '0;
        end else begin
            last_q    <= last_d;
            wr_en_q   <= wr_en_d;
            err_q     <= err_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            pending_q <= pending_d;
        end
    end

    assign wr_en_o        = wr_en_q;
    assign wr_addr_o      = wr_addr_q;
    assign wr_data_o      = wr_data_q;
    assign err_pc_write_o = err_q;

    // No bypass of the in-flight write: the commit edge is what clears busy.
    always_comb begin
        for (int j = 0; j < 3; j++)
            busy_o[j] = pending_q[chk_addr_i[4*j +: 4]];
    end
    assign stall_o = |(busy_o & chk_en_i);

`ifdef REG_ARB_STATS_EN
    logic [15:0] conflict_cnt_q, conflict_cnt_d;

    always_comb begin
        conflict_cnt_d = conflict_cnt_q;
        if ($countones(req_valid_i) >= 2 && conflict_cnt_q != 16'hFFFF)
            conflict_cnt_d = conflict_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            conflict_cnt_q <= '0;
        else
            conflict_cnt_q <= conflict_cnt_d;
    end

    assign conflict_cnt_o = conflict_cnt_q;
`endif
endmodule

// File: tb/tb_reg_write_arbiter.sv
// Scoreboard bench for reg_write_arbiter: directed scenarios plus random traffic
// checked against a behavioural model of grants, writes and pending registers.
module tb_reg_write_arbiter;
    localparam int N    = 32;
    localparam int NREQ = 3;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NREQ-1:0]   req_valid_i = '0;
    logic [4*NREQ-1:0] req_addr_i = '0;
    logic [N*NREQ-1:0] req_data_i = '0;
    logic [NREQ-1:0]   req_ready_o;
    logic              wr_en_o;
    logic [3:0]        wr_addr_o;
    logic [N-1:0]      wr_data_o;
    logic              err_pc_write_o;
    logic              reserve_valid_i = 1'b0;
    logic [3:0]        reserve_addr_i = '0;
    logic [11:0]       chk_addr_i = '0;
    logic [2:0]        chk_en_i = '0;
    logic [2:0]        busy_o;
    logic              stall_o;
`ifdef REG_ARB_STATS_EN
    logic [15:0]       conflict_cnt_o;
`endif

    reg_write_arbiter #(.N(N), .NREQ(NREQ)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid_i(req_valid_i), .req_addr_i(req_addr_i), .req_data_i(req_data_i),
        .req_ready_o(req_ready_o),
        .wr_en_o(wr_en_o), .wr_addr_o(wr_addr_o), .wr_data_o(wr_data_o),
        .err_pc_write_o(err_pc_write_o),
        .reserve_valid_i(reserve_valid_i), .reserve_addr_i(reserve_addr_i),
        .chk_addr_i(chk_addr_i), .chk_en_i(chk_en_i),
        .busy_o(busy_o), .stall_o(stall_o)
`ifdef REG_ARB_STATS_EN
        , .conflict_cnt_o(conflict_cnt_o)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        bit           r15;
        logic [3:0]   addr;
        logic [N-1:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  checks = 0;
    int  errors = 0;

    // Requester side of the model: each requester holds its request until granted.
    logic [NREQ-1:0] v_m;
    logic [3:0]      a_m[NREQ];
    logic [N-1:0]    d_m[NREQ];
    logic            res_v;
    logic [3:0]      res_a;
    logic [11:0]     chk_a;
    logic [2:0]      chk_e;
    int              last_m;
    bit              pend_m[16];
    bit              m_wr_en;
    logic [3:0]      m_wr_addr;
    int              g_m;
    int              cnt_m;
    logic [NREQ-1:0] rdy_cap;
    logic [2:0]      busy_cap;
    logic            stall_cap;
    logic            wen_cap;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && (wr_en_o || err_pc_write_o)) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_write", {wr_en_o, err_pc_write_o}, 2'b00);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("wr_en", wr_en_o, !e.r15);
                chk("err_pc", err_pc_write_o, e.r15);
                if (!e.r15) begin
                    chk("wr_addr", wr_addr_o, e.addr);
                    chk("wr_data", wr_data_o, e.data);
                end
            end
        end
    end

    task automatic apply();
        for (int k = 0; k < NREQ; k++) begin
            req_valid_i[k]        = v_m[k];
            req_addr_i[4*k +: 4]  = a_m[k];
            req_data_i[N*k +: N]  = d_m[k];
        end
        reserve_valid_i = res_v;
        reserve_addr_i  = res_a;
        chk_addr_i      = chk_a;
        chk_en_i        = chk_e;
    endtask

    task automatic drive();
        logic [NREQ-1:0] er;
        logic [2:0]      eb;
        int              k;
        apply();
        #1;
        g_m = -1;
        for (int i = 1; i <= NREQ; i++) begin
            k = (last_m + i) % NREQ;
            if (g_m < 0 && v_m[k]) g_m = k;
        end
        er = '0;
        if (g_m >= 0) er[g_m] = 1'b1;
        for (int j = 0; j < 3; j++) eb[j] = pend_m[chk_a[4*j +: 4]];
        rdy_cap   = req_ready_o;
        busy_cap  = busy_o;
        stall_cap = stall_o;
        wen_cap   = wr_en_o;
        chk("ready", req_ready_o, er);
        chk("busy", busy_o, eb);
        chk("stall", stall_o, |(eb & chk_e));
    endtask

    task automatic update();
        wr_t e;
        @(posedge clk);
        chk("sb_backlog", exp_q.size(), 0);
        if ($countones(v_m) >= 2 && cnt_m < 16'hFFFF) cnt_m++;
        if (m_wr_en) pend_m[m_wr_addr] = 1'b0;
        if (res_v && res_a != 4'd15) pend_m[res_a] = 1'b1;
        m_wr_en = 1'b0;
        if (g_m >= 0) begin
            e.r15  = (a_m[g_m] == 4'd15);
            e.addr = a_m[g_m];
            e.data = d_m[g_m];
            exp_q.push_back(e);
            m_wr_en   = !e.r15;
            m_wr_addr = a_m[g_m];
            last_m    = g_m;
            v_m[g_m]  = 1'b0;
        end
    endtask

    task automatic step();
        @(negedge clk);
        drive();
        update();
    endtask

    task automatic req(input int k, input logic [3:0] a, input logic [N-1:0] d);
        v_m[k] = 1'b1;
        a_m[k] = a;
        d_m[k] = d;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        v_m = '0; res_v = 1'b0; res_a = '0; chk_a = '0; chk_e = '0;
        for (int k = 0; k < NREQ; k++) begin a_m[k] = '0; d_m[k] = '0; end
        apply();
        exp_q.delete();
        last_m = NREQ - 1;
        for (int i = 0; i < 16; i++) pend_m[i] = 1'b0;
        m_wr_en = 1'b0; m_wr_addr = '0; cnt_m = 0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();
        // Reset state (release happened at posedge+2; outputs must still be reset values)
        chk("rst_wr_en", wr_en_o, 1'b0);
        chk("rst_wr_addr", wr_addr_o, 4'd0);
        chk("rst_wr_data", wr_data_o, '0);
        chk("rst_err", err_pc_write_o, 1'b0);
        chk("rst_busy", busy_o, 3'b000);

        // Scenario 1: all three valid -> grants 0,1,2 with back-to-back writes
        req(0, 4'd1, 32'h1111_0001);
        req(1, 4'd2, 32'h2222_0002);
        req(2, 4'd4, 32'h4444_0004);
        step(); chk("s1_g0", rdy_cap, 3'b001);
        step(); chk("s1_g1", rdy_cap, 3'b010); chk("s1_wen0", wr_en_o, 1'b1);
        step(); chk("s1_g2", rdy_cap, 3'b100); chk("s1_wen1", wr_en_o, 1'b1);
        #1 chk("s1_wen2", wr_en_o, 1'b1);

        // Scenario 2: R15 from requester 1 is dropped with an error pulse
        req(1, 4'd15, 32'hDEAD_BEEF);
        step(); chk("s2_rdy", rdy_cap, 3'b010);
        #1 chk("s2_wen", wr_en_o, 1'b0); chk("s2_err", err_pc_write_o, 1'b1);
        step();
        #1 chk("s2_err_fall", err_pc_write_o, 1'b0);

        // Scenario 3: reserve R3, stall until the ALU's write commits
        res_v = 1'b1; res_a = 4'd3;
        step();
        res_v = 1'b0; chk_a = 12'h003; chk_e = 3'b001;
        req(0, 4'd3, 32'h0000_1234);
        step(); chk("s3_busy", busy_cap[0], 1'b1); chk("s3_stall", stall_cap, 1'b1);
        step(); chk("s3_stall_wen", stall_cap, 1'b1); chk("s3_wen", wen_cap, 1'b1);
        step(); chk("s3_stall_fall", stall_cap, 1'b0);

        // Scenario 4: commit and reserve of R5 in the same cycle -> set wins
        res_v = 1'b1; res_a = 4'd5; chk_a = 12'h005;
        step();
        res_v = 1'b0;
        req(2, 4'd5, 32'h5555_5555);
        step();
        res_v = 1'b1; res_a = 4'd5;
        step(); chk("s4_wen", wen_cap, 1'b1);
        res_v = 1'b0;
        step(); chk("s4_busy", busy_cap[0], 1'b1);

        // Scenario 5: reset while a write is on the port and pending = 16'h00F0
        chk_a = {4'd6, 4'd5, 4'd4}; chk_e = 3'b111;
        res_v = 1'b1; res_a = 4'd4; step();
        res_a = 4'd6; step();
        res_a = 4'd7; req(0, 4'd1, 32'hCAFE_0001); step();
        res_v = 1'b0;
        #2 chk("s5_pre_wen", wr_en_o, 1'b1); chk("s5_pre_busy", busy_o, 3'b111);
        rst_n = 1'b0;
        #1 chk("s5_rst_wen", wr_en_o, 1'b0); chk("s5_rst_busy", busy_o, 3'b000);
        do_reset();
        req(0, 4'd8, 32'h0808_0808); req(1, 4'd9, 32'h0909_0909); req(2, 4'd10, 32'h0A0A_0A0A);
        step(); chk("s5_first_grant", rdy_cap, 3'b001);
        step(); step();

        // Random traffic against the model
        for (int c = 0; c < 1500; c++) begin
            for (int k = 0; k < NREQ; k++)
                if (!v_m[k] && $urandom_range(0, 99) < 55)
                    req(k, 4'($urandom_range(0, 15)), $urandom);
            res_v = ($urandom_range(0, 2) == 0);
            res_a = 4'($urandom_range(0, 15));
            if (pend_m[res_a]) res_v = 1'b0;
            chk_a = 12'($urandom);
            chk_e = 3'($urandom);
            step();
        end

`ifdef REG_ARB_STATS_EN
        // Scenario 6: conflict counter, exact count then saturation
        do_reset();
        for (int c = 0; c < 5; c++) begin
            if (!v_m[0]) req(0, 4'd11, $urandom);
            if (!v_m[1]) req(1, 4'd12, $urandom);
            step();
        end
        step();
        req(2, 4'd13, 32'h1313_1313);
        step();
        #1 chk("s6_cnt5", conflict_cnt_o, 16'd5); chk("s6_cnt_model", conflict_cnt_o, 16'(cnt_m));
        force dut.conflict_cnt_q = 16'hFFFD;
        @(negedge clk);
        release dut.conflict_cnt_q;
        cnt_m = 16'hFFFD;
        for (int c = 0; c < 4; c++) begin
            if (!v_m[0]) req(0, 4'd11, $urandom);
            if (!v_m[1]) req(1, 4'd12, $urandom);
            step();
        end
        #1 chk("s6_sat", conflict_cnt_o, 16'hFFFF); chk("s6_sat_model", conflict_cnt_o, 16'(cnt_m));
`endif

        // Drain outstanding requests, then every expected write must have appeared
        res_v = 1'b0;
        for (int c = 0; c < NREQ + 2; c++) step();
        @(negedge clk); #1;
        chk("sb_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
